irst_seq: RTL
=============

IRST_SEQ -- requirements
Module: irst_seq

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have: irst_reg_data  input  16  register-0 word from the register file: [15] enable, [11:8] pattern nibble, [2:0] last register index.
REQ-004 SHALL have: irst_done  output  1  one-cycle pulse that tells the register file to clear register 0.
REQ-005 SHALL have: reg_write_en / reg_write_dest / reg_write_data  output  1/3/16  engine-owned write port, muxed into the register file while busy.
REQ-006 SHALL have: reg_read_addr  output  3  engine read address, muxed onto register-file read port 1 while busy.
REQ-007 SHALL have: reg_read_data  input  16  asynchronous read data from read port 1.
REQ-008 SHALL have: irst_busy  output  1  high in every non-IDLE state; the pipeline stalls and the muxes select the engine.
REQ-009 SHALL have: irst_pass  output  1  result of the last run; 1 means no miscompare.
REQ-010 SHALL have: irst_fail_addr  output  3  register index of the first miscompare in the last run; 0 if there was none.

Function
REQ-011 SHALL derive PAT = {4{irst_reg_data[11:8]}} (16 bits) and N = irst_reg_data[2:0], both latched on the IDLE->WR transition.
REQ-012 SHALL use the states IDLE, WR, RD, CLR and DONE.
REQ-013 SHALL go IDLE->WR when irst_reg_data[15]=1 and N!=0; IDLE->DONE when [15]=1 and N=0; otherwise SHALL stay in IDLE.
REQ-014 SHALL, in WR, drive reg_write_en=1, reg_write_dest=idx and reg_write_data=PAT, then go to RD; idx starts at 1 each pass.
REQ-015 SHALL, in RD, drive reg_read_addr=idx and compare reg_read_data against PAT in the same cycle (read is combinational).
REQ-016 SHALL, on an RD miscompare, clear irst_pass; if this is the first miscompare of the run it SHALL also load irst_fail_addr=idx.
REQ-017 SHALL, from RD, go to WR with idx+1 if idx<N; if idx=N it SHALL go to CLR with idx=1.
REQ-018 SHALL, in CLR, write 16'h0000 to register idx, one register per cycle for idx=1..N, then go to DONE.
REQ-019 SHALL, in DONE, assert irst_done for exactly one cycle and then go to IDLE.
REQ-020 SHALL keep reg_write_en=0 in IDLE, RD and DONE.
REQ-021 SHALL ignore changes to irst_reg_data while busy.
REQ-022 SHALL not retrigger after DONE: register 0 clears on the same edge that leaves DONE.
REQ-023 SHALL set irst_pass=1 and irst_fail_addr=0 on each IDLE->WR or IDLE->DONE transition; both then hold until the next run starts.
REQ-024 SHALL reach DONE with irst_pass=1 when N=0, with no register writes.
REQ-025 SHALL never use index 0 as a write or read target.
REQ-026 SHALL have run length 3N+1 busy cycles with IRST_INV_PASS_EN undefined.

Reset
REQ-027 SHALL, on rst, go to IDLE immediately, including mid-run, with no completion of the current step.
REQ-028 SHALL reset outputs to: irst_busy=0, irst_done=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0, reg_read_addr=0, irst_pass=1, irst_fail_addr=0.
REQ-029 SHALL start a run on the first clock after rst deasserts if irst_reg_data[15]=1; the register file resets register 0 to 16'h8F04.

Configuration
REQ-030 SHALL, with IRST_INV_PASS_EN defined, run a second WR/RD pass over idx=1..N with ~PAT between the first pass and CLR; run length becomes 5N+1 busy cycles.
REQ-031 SHALL, with IRST_INV_PASS_EN undefined, run the single PAT pass only; REQ-016 applies to either pass.

Verification
REQ-032 SHALL cover: reset releases with reg0=16'h8F04 and a healthy register file -> writes 16'hFFFF to r1..r4, busy for 13 cycles, irst_pass=1, fail_addr=0, one irst_done pulse, r1..r4=0 afterwards.
REQ-033 SHALL cover: same as REQ-032 but the register file model forces bit 0 of r3 to 0 -> irst_pass=0, irst_fail_addr=3, r1..r4 cleared.
REQ-034 SHALL cover: reg0=16'h8A00 (N=0) -> busy for 1 cycle (DONE), no write, irst_pass=1.
REQ-035 SHALL cover: rst asserted during the RD of idx=2 -> all outputs at reset values in the same cycle, no irst_done pulse.
REQ-036 SHALL cover: IRST_INV_PASS_EN defined, reg0=16'h8502 -> writes 16'h5555 then 16'hAAAA to r1..r2, busy for 11 cycles, irst_pass=1.
REQ-037 SHALL cover: irst_reg_data changed to 16'h8F07 mid-run -> run completes with N=4 and the original PAT.

Source files
------------

// File: rtl/irst_seq_if.sv
// Register-file side bus of the self-test sequencer.
// master: engine side (drives writes/read address/status); slave: register-file side.
// Carries reg0 word, engine write/read port, and the run status.
interface irst_seq_if;
  logic [15:0] irst_reg_data;
  logic        irst_done;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [2:0]  reg_read_addr;
  logic [15:0] reg_read_data;
  logic        irst_busy;
  logic        irst_pass;
  logic [2:0]  irst_fail_addr;

  modport master (
    input  irst_reg_data,
    input  reg_read_data,
    output irst_done,
    output reg_write_en,
    output reg_write_dest,
    output reg_write_data,
    output reg_read_addr,
    output irst_busy,
    output irst_pass,
    output irst_fail_addr
  );

  modport slave (
    output irst_reg_data,
    output reg_read_data,
    input  irst_done,
    input  reg_write_en,
    input  reg_write_dest,
    input  reg_write_data,
    input  reg_read_addr,
    input  irst_busy,
    input  irst_pass,
    input  irst_fail_addr
  );
endinterface

// File: rtl/irst_seq.sv
// Register-file self-test sequencer: writes a pattern to r1..rN, reads it back, then clears r1..rN.
// Latency: 3N+1 busy cycles (5N+1 with IRST_INV_PASS_EN, which adds an inverted-pattern pass).
// No backpressure: the pipeline is stalled via irst_busy for the whole run; reg0 is ignored while busy.
module irst_seq (
  input  logic       clk,
  input  logic       rst,
  irst_seq_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic [2:0]  r_n;
  logic [15:0] r_pat;
  logic        r_pass;
  logic [2:0]  r_fail_addr;

  logic [15:0] w_exp;
  logic        w_start;
  logic        w_miss;
  logic        w_unused_bits;

`ifdef IRST_INV_PASS_EN
  logic r_inv;
  assign w_exp = r_inv ? ~r_pat : r_pat;
`else
  assign w_exp = r_pat;
`endif

  assign w_start       = bus.irst_reg_data[15];
  assign w_miss        = (r_state == S_RD) && (bus.reg_read_data != w_exp);
  assign w_unused_bits = ^{bus.irst_reg_data[14:12], bus.irst_reg_data[7:3]};

  // Sequencer state, index and latched run parameters/results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_n         <= 3'd0;
      r_pat       <= 16'h0000;
      r_pass      <= 1'b1;
      r_fail_addr <= 3'd0;
`ifdef IRST_INV_PASS_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pass      <= 1'b1;
            r_fail_addr <= 3'd0;
            r_idx       <= 3'd1;
            r_n         <= bus.irst_reg_data[2:0];
            r_pat       <= {4{bus.irst_reg_data[11:8]}};
`ifdef IRST_INV_PASS_EN
            r_inv       <= 1'b0;
`endif
            r_state     <= (bus.irst_reg_data[2:0] != 3'd0) ? S_WR : S_DONE;
          end
        end
        S_WR: begin
          r_state <= S_RD;
        end
        S_RD: begin
          if (w_miss) begin
            r_pass <= 1'b0;
            // r_pass still high means no earlier miscompare in this run
            if (r_pass) begin
              r_fail_addr <= r_idx;
            end
          end
          if (r_idx < r_n) begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_WR;
          end else begin
            r_idx <= 3'd1;
`ifdef IRST_INV_PASS_EN
            if (!r_inv) begin
              r_inv   <= 1'b1;
              r_state <= S_WR;
            end else begin
              r_state <= S_CLR;
            end
`else
            r_state <= S_CLR;
`endif
          end
        end
        S_CLR: begin
          if (r_idx == r_n) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state; reset drops every strobe in the same cycle.
  always_comb begin
    bus.reg_write_en   = 1'b0;
    bus.reg_write_dest = 3'd0;
    bus.reg_write_data = 16'h0000;
    bus.reg_read_addr  = 3'd0;
    bus.irst_done      = 1'b0;
    bus.irst_busy      = (r_state != S_IDLE);
    case (r_state)
      S_WR: begin
        bus.reg_write_en   = 1'b1;
        bus.reg_write_dest = r_idx;
        bus.reg_write_data = w_exp;
      end
      S_RD: begin
        bus.reg_read_addr = r_idx;
      end
      S_CLR: begin
        bus.reg_write_en   = 1'b1;
        bus.reg_write_dest = r_idx;
        bus.reg_write_data = 16'h0000;
      end
      S_DONE: begin
        bus.irst_done = 1'b1;
      end
      default: begin
        bus.reg_write_en = 1'b0;
      end
    endcase
  end

  assign bus.irst_pass      = r_pass;
  assign bus.irst_fail_addr = r_fail_addr;

endmodule
